frame_dump_trigger: RTL and testbench

- Synthesizable producer of the frame count and dump-window signals that the simulation dump controller consumes.
- Counts vertical-sync falling edges and holds off while a ROM download is in progress.
- Opens a dump window at a programmed frame and closes it at a second programmed frame.
- Sits in the test harness next to the game top level, fed by raw VGA_VS and the download/LED signal.

---
 rtl/frame_dump_trigger_pkg.sv | 24 ++
 rtl/frame_dump_trigger_sync_edge.sv | 34 +++
 rtl/frame_dump_trigger.sv | 159 +++++++++++++++
 tb/tb_frame_dump_trigger.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_dump_trigger_pkg.sv
// Shared types and constants for the frame dump trigger block.
package frame_dump_trigger_pkg;

  // Trigger sequencer states.
  typedef enum logic [2:0] {
    WAIT_DL = 3'd0,
    HOLD    = 3'd1,
    ARMED   = 3'd2,
    DUMPING = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Synchronizer depths: vs needs an extra stage for its edge detector.
  localparam int VS_SYNC_STAGES = 3;
  localparam int DL_SYNC_STAGES = 2;

  // Width of a down-counter that must hold values 0..holdoff.
  function automatic int holdoff_cnt_w(input int holdoff);
    int w;
    w = $clog2(holdoff + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frame_dump_trigger_sync_edge.sv
// Generic N-flop synchronizer with a falling-edge flag taken between the
// last two stages. STAGES must be at least 2.
module frame_sync_edge #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle (bit 0 is the first flop).
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer chain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync = sync_q[STAGES-1];
  assign fall = sync_q[STAGES-1] & ~sync_q[STAGES-2];

endmodule

// File: rtl/frame_dump_trigger.sv
// Frame counter and dump-window sequencer driven by raw VGA vsync and the
// ROM download indicator. Counts vsync falling edges since the end of the
// last download and opens/closes a dump window at programmed frame numbers.
module frame_dump_trigger
  import frame_dump_trigger_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int START_FRAME = 0,
  parameter int STOP_FRAME  = 0,
  parameter int HOLDOFF     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vs,
  input  logic             downloading,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             dump_on,
  output logic             dump_start,
  output logic             dump_stop,
  output logic             done
);

  localparam int               HO_W      = holdoff_cnt_w(HOLDOFF);
  localparam logic [HO_W-1:0]  HOLD_LOAD = HO_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] START_VAL = CNT_W'(START_FRAME);
  localparam logic [CNT_W-1:0] STOP_VAL  = CNT_W'(STOP_FRAME);
  localparam bit               STOP_EN   = (STOP_FRAME != 0);

  logic vs_s;
  logic vs_fall;
  logic dl_s;
  logic dl_fall;

  frame_sync_edge #(
    .STAGES  (VS_SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_vs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (vs),
    .sync  (vs_s),
    .fall  (vs_fall)
  );

  // Only the level of the download flag matters; its edge output is unused.
  frame_sync_edge #(
    .STAGES  (DL_SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_dl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (downloading),
    .sync  (dl_s),
    .fall  (dl_fall)
  );

  state_e           state_q, state_d;
  logic [HO_W-1:0]  holdoff_q, holdoff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dump_on_q, dump_on_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;

  // Next-state logic: frame counting, arming hold-off and window control.
  always_comb begin
    state_d   = state_q;
    holdoff_d = holdoff_q;
    cnt_d     = cnt_q;
    dump_on_d = dump_on_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    done_d    = done_q;

    // Counting runs whenever no download is active; matches below use cnt_q,
    // i.e. the value before this fall's increment.
    if (dl_s) begin
      cnt_d = '0;
    end else if (vs_fall) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (dl_s && (state_q != WAIT_DL)) begin
      // A new download aborts everything; an open window is closed cleanly
      // but is not reported as done.
      state_d = WAIT_DL;
      done_d  = 1'b0;
      if (dump_on_q) begin
        dump_on_d = 1'b0;
        stop_d    = 1'b1;
      end
    end else begin
      case (state_q)
        WAIT_DL: begin
          if (!dl_s) begin
            holdoff_d = HOLD_LOAD;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (holdoff_q == '0) begin
            state_d = ARMED;
          end else begin
            holdoff_d = holdoff_q - 1'b1;
          end
        end
        ARMED: begin
          if (vs_fall && (cnt_q == START_VAL)) begin
            dump_on_d = 1'b1;
            start_d   = 1'b1;
            state_d   = DUMPING;
          end
        end
        DUMPING: begin
          if (STOP_EN && vs_fall && (cnt_q == STOP_VAL)) begin
            dump_on_d = 1'b0;
            stop_d    = 1'b1;
            done_d    = 1'b1;
            state_d   = DONE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = WAIT_DL;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_DL;
      holdoff_q <= '0;
      cnt_q     <= '0;
      dump_on_q <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdoff_q <= holdoff_d;
      cnt_q     <= cnt_d;
      dump_on_q <= dump_on_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
    end
  end

  assign frame_cnt  = cnt_q;
  assign dump_on    = dump_on_q;
  assign dump_start = start_q;
  assign dump_stop  = stop_q;
  assign done       = done_q;

endmodule

// File: tb/tb_frame_dump_trigger.sv
// Bench for frame_dump_trigger: three instances with different window
// settings share one stimulus; a frame-level vector table drives each phase.
module tb_frame_dump_trigger;
  import frame_dump_trigger_pkg::*;

  localparam int OP_ARM  = 0;
  localparam int OP_FALL = 1;
  localparam int OP_DL   = 2;

  typedef struct {
    int          op;
    int          dut;
    logic [31:0] cnt;
    logic        on;
    logic        start;
    logic        stop;
    logic        done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b1;
  logic downloading = 1'b1;

  logic [31:0] fc_a, fc_b;
  logic [3:0]  fc_c;
  logic on_a, st_a, sp_a, dn_a;
  logic on_b, st_b, sp_b, dn_b;
  logic on_c, st_c, sp_c, dn_c;

  int n_vec = 0;
  int n_err = 0;
  int n_overlap = 0;
  int n_wide = 0;
  int n_start[3];
  int n_stop[3];
  logic [3:0] prev_b[3];
  logic [3:0] mon_b;
  logic [31:0] last_cnt;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  frame_dump_trigger #(.CNT_W(32), .START_FRAME(0), .STOP_FRAME(3), .HOLDOFF(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
    .frame_cnt(fc_a), .dump_on(on_a), .dump_start(st_a), .dump_stop(sp_a), .done(dn_a));

  frame_dump_trigger #(.CNT_W(32), .START_FRAME(2), .STOP_FRAME(0), .HOLDOFF(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
    .frame_cnt(fc_b), .dump_on(on_b), .dump_start(st_b), .dump_stop(sp_b), .done(dn_b));

  frame_dump_trigger #(.CNT_W(4), .START_FRAME(14), .STOP_FRAME(1), .HOLDOFF(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
    .frame_cnt(fc_c), .dump_on(on_c), .dump_start(st_c), .dump_stop(sp_c), .done(dn_c));

  function automatic logic [31:0] obs_cnt(input int d);
    case (d)
      0: return fc_a;
      1: return fc_b;
      default: return {28'd0, fc_c};
    endcase
  endfunction

  // {dump_on, dump_start, dump_stop, done}
  function automatic logic [3:0] obs_bits(input int d);
    case (d)
      0: return {on_a, st_a, sp_a, dn_a};
      1: return {on_b, st_b, sp_b, dn_b};
      default: return {on_c, st_c, sp_c, dn_c};
    endcase
  endfunction

  function automatic state_e obs_state(input int d);
    case (d)
      0: return dut_a.state_q;
      1: return dut_b.state_q;
      default: return dut_c.state_q;
    endcase
  endfunction

  task automatic add(input int op, input int d, input logic [31:0] c,
                     input logic on, input logic st, input logic sp, input logic dn);
    vec_t v;
    v.op = op; v.dut = d; v.cnt = c; v.on = on; v.start = st; v.stop = sp; v.done = dn;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rec(input int i, input vec_t e);
    logic [3:0] b;
    b = obs_bits(e.dut);
    check($sformatf("v%0d.frame_cnt", i), obs_cnt(e.dut), e.cnt);
    check($sformatf("v%0d.dump_on", i), 32'(b[3]), 32'(e.on));
    check($sformatf("v%0d.dump_start", i), 32'(b[2]), 32'(e.start));
    check($sformatf("v%0d.dump_stop", i), 32'(b[1]), 32'(e.stop));
    check($sformatf("v%0d.done", i), 32'(b[0]), 32'(e.done));
  endtask

  // Pulse monitor: counts pulses since reset, flags start/stop overlap and
  // pulses wider than one clock on any instance.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      mon_b = obs_bits(k);
      if (!rst_n) begin
        n_start[k] = 0;
        n_stop[k] = 0;
      end else begin
        if (mon_b[2]) n_start[k]++;
        if (mon_b[1]) n_stop[k]++;
        if (mon_b[2] && mon_b[1]) n_overlap++;
        if ((mon_b[2] && prev_b[k][2]) || (mon_b[1] && prev_b[k][1])) n_wide++;
      end
      prev_b[k] = mon_b;
    end
  end

  // Reset all instances, run a 100-clock download with vs toggling, release
  // it and confirm the arming point of instance d.
  task automatic do_arm(input int d);
    @(negedge clk);
    rst_n = 1'b0; downloading = 1'b1; vs = 1'b1;
    repeat (5) @(negedge clk);
    check($sformatf("rst%0d.frame_cnt", d), obs_cnt(d), 32'd0);
    check($sformatf("rst%0d.bits", d), 32'(obs_bits(d)), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      vs = 1'b0;
      repeat (5) @(negedge clk);
      vs = 1'b1;
      repeat (5) @(negedge clk);
      check($sformatf("dl%0d.frame_cnt_k%0d", d, k), obs_cnt(d), 32'd0);
    end
    downloading = 1'b0;
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1;
    check($sformatf("arm%0d.state_n17", d), 32'(obs_state(d)), 32'(HOLD));
    @(posedge clk);
    #1;
    check($sformatf("arm%0d.state_n18", d), 32'(obs_state(d)), 32'(ARMED));
    repeat (5) @(negedge clk);
    check($sformatf("arm%0d.start_pulses", d), 32'(n_start[d]), 32'd0);
    check($sformatf("arm%0d.stop_pulses", d), 32'(n_stop[d]), 32'd0);
    check($sformatf("arm%0d.frame_cnt", d), obs_cnt(d), 32'd0);
    last_cnt = 32'd0;
  endtask

  // One vsync period whose falling edge is checked at edges N+1, N+2, N+3.
  task automatic do_fall(input int i, input vec_t v);
    vec_t e;
    @(negedge clk);
    vs = 1'b0;
    sb.push_back(v);
    @(posedge clk);
    @(posedge clk);
    #1;
    check($sformatf("v%0d.lat_cnt", i), obs_cnt(v.dut), last_cnt);
    check($sformatf("v%0d.lat_pulses", i), 32'(obs_bits(v.dut) & 4'b0110), 32'd0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_rec(i, e);
    @(posedge clk);
    #1;
    check($sformatf("v%0d.pulse_width", i), 32'(obs_bits(v.dut) & 4'b0110), 32'd0);
    last_cnt = e.cnt;
    repeat (20) @(negedge clk);
    vs = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  // Download asserted mid-operation, then released and re-armed.
  task automatic do_dl(input int i, input vec_t v);
    vec_t e;
    @(negedge clk);
    downloading = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    @(posedge clk);
    #1;
    check($sformatf("v%0d.lat_cnt", i), obs_cnt(v.dut), last_cnt);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_rec(i, e);
    @(posedge clk);
    #1;
    check($sformatf("v%0d.pulse_width", i), 32'(obs_bits(v.dut) & 4'b0110), 32'd0);
    repeat (30) @(negedge clk);
    downloading = 1'b0;
    repeat (25) @(negedge clk);
    check($sformatf("v%0d.rearm_state", i), 32'(obs_state(v.dut)), 32'(ARMED));
    last_cnt = 32'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Phase A: window 0..3 on dut_a, done sticky, cleared by download.
    add(OP_ARM, 0, 0, 0, 0, 0, 0);
    add(OP_FALL, 0, 1, 1, 1, 0, 0);
    add(OP_FALL, 0, 2, 1, 0, 0, 0);
    add(OP_FALL, 0, 3, 1, 0, 0, 0);
    add(OP_FALL, 0, 4, 0, 0, 1, 1);
    for (int k = 5; k <= 8; k++) add(OP_FALL, 0, k, 0, 0, 0, 1);
    add(OP_DL, 0, 0, 0, 0, 0, 0);
    add(OP_FALL, 0, 1, 1, 1, 0, 0);
    // Phase B: start at 2, never stop; download during frame 5.
    add(OP_ARM, 1, 0, 0, 0, 0, 0);
    add(OP_FALL, 1, 1, 0, 0, 0, 0);
    add(OP_FALL, 1, 2, 0, 0, 0, 0);
    add(OP_FALL, 1, 3, 1, 1, 0, 0);
    add(OP_FALL, 1, 4, 1, 0, 0, 0);
    add(OP_FALL, 1, 5, 1, 0, 0, 0);
    add(OP_DL, 1, 0, 0, 0, 1, 0);
    add(OP_FALL, 1, 1, 0, 0, 0, 0);
    add(OP_FALL, 1, 2, 0, 0, 0, 0);
    add(OP_FALL, 1, 3, 1, 1, 0, 0);
    // Phase C: 4-bit counter, window 14..1 across the wrap.
    add(OP_ARM, 2, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 14; k++) add(OP_FALL, 2, k, 0, 0, 0, 0);
    add(OP_FALL, 2, 15, 1, 1, 0, 0);
    add(OP_FALL, 2, 0, 1, 0, 0, 0);
    add(OP_FALL, 2, 1, 1, 0, 0, 0);
    add(OP_FALL, 2, 2, 0, 0, 1, 1);
    add(OP_FALL, 2, 3, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      $display("vec %0d: op %0d dut %0d exp cnt %0d on %0d start %0d stop %0d done %0d",
               i, tbl[i].op, tbl[i].dut, tbl[i].cnt, tbl[i].on, tbl[i].start,
               tbl[i].stop, tbl[i].done);
      case (tbl[i].op)
        OP_ARM:  do_arm(tbl[i].dut);
        OP_FALL: do_fall(i, tbl[i]);
        default: do_dl(i, tbl[i]);
      endcase
    end

    // Narrow vs pulses, 1 clk low each: exactly one count per real edge.
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      vs = 1'b0;
      @(negedge clk);
      vs = 1'b1;
      repeat (3) @(negedge clk);
      check($sformatf("narrow%0d.frame_cnt", k), obs_cnt(2), last_cnt + 32'(k));
    end
    $display("narrow vs pulses: 5 applied");

    // Fall and download rise in the same cycle: download wins.
    do_arm(0);
    @(negedge clk);
    vs = 1'b0;
    downloading = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("simul.frame_cnt", obs_cnt(0), 32'd0);
    check("simul.bits_n2", 32'(obs_bits(0)), 32'd0);
    @(posedge clk);
    #1;
    check("simul.bits_n3", 32'(obs_bits(0)), 32'd0);
    check("simul.start_pulses", 32'(n_start[0]), 32'd0);
    check("simul.state", 32'(obs_state(0)), 32'(WAIT_DL));
    $display("simultaneous fall/download applied");
    vs = 1'b1;
    repeat (10) @(negedge clk);

    check("global.start_stop_overlap", 32'(n_overlap), 32'd0);
    check("global.wide_pulses", 32'(n_wide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
